// File: rtl/dcpu_mem_responder.sv
// dcpu bus target: windowed 2^AW x 16 RAM with WAIT wait states before a one-cycle ack.
// Define DCPU_MEM_WPROT_EN to block writes below WP_LIMIT and flag them on o_wp_err.
module dcpu_mem_responder #(
    parameter int unsigned AW       = 10,
    parameter logic [15:0] BASE     = 16'h0000,
    parameter int unsigned WAIT     = 0,
    parameter logic [15:0] WP_LIMIT = 16'h0100
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [15:0] i_addr,
    input  logic [15:0] i_dat,
    output logic [15:0] o_dat,
    input  logic        i_we,
    input  logic        i_cs,
    output logic        o_ack
`ifdef DCPU_MEM_WPROT_EN
    ,
    output logic        o_wp_err
`endif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    localparam logic [3:0] WLOAD = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [15:0]   wdat_q, wdat_d;
    logic          we_q, we_d;
    logic [15:0]   rdat_q;
    logic [15:0]   mem [0:(1<<AW)-1];

    logic sel;
    logic enter_ack;
    logic commit;

    assign sel = i_cs && (i_addr[15:AW] == BASE[15:AW]);

`ifdef DCPU_MEM_WPROT_EN
    logic prot_q, prot_d;
    logic wp_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        wdat_d  = wdat_q;
        we_d    = we_q;
`ifdef DCPU_MEM_WPROT_EN
        prot_d  = prot_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (sel) begin
                    idx_d  = i_addr[AW-1:0];
                    wdat_d = i_dat;
                    we_d   = i_we;
`ifdef DCPU_MEM_WPROT_EN
                    prot_d = (i_addr < WP_LIMIT);
`endif
                    if (WAIT == 0) begin
                        state_d = S_ACK;
                    end else begin
                        cnt_d   = WLOAD;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // a dropped request wins over a pending ack
                if (!i_cs) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign enter_ack = (state_d == S_ACK);

`ifdef DCPU_MEM_WPROT_EN
    assign commit = enter_ack && we_d && !prot_d;
`else
    assign commit = enter_ack && we_d;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            wdat_q  <= 16'h0000;
            we_q    <= 1'b0;
            rdat_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdat_q  <= wdat_d;
            we_q    <= we_d;
            if (enter_ack && !we_d) begin
                rdat_q <= mem[idx_d];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && commit) begin
            mem[idx_d] <= wdat_d;
        end
    end

`ifdef DCPU_MEM_WPROT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prot_q <= 1'b0;
            wp_q   <= 1'b0;
        end else begin
            prot_q <= prot_d;
            if (enter_ack && we_d && prot_d) begin
                wp_q <= 1'b1;
            end
        end
    end

    assign o_wp_err = wp_q;
`endif

    assign o_ack = (state_q == S_ACK);
    assign o_dat = rdat_q;

endmodule

// File: tb/tb_dcpu_mem_responder.sv
// Bench for dcpu_mem_responder: three instances share one bus, a fourth
// (write-protect window) sits on its own chip select.
module tb_dcpu_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [15:0] wdat;
  logic        we;
  logic        cs;
  logic        cs_w;
  logic [15:0] dat [4];
  logic [3:0]  ack;
  logic [3:0]  wpe;
  logic        wperr;

  int errs;
  int checks;

  always #5 clk = ~clk;

`ifdef DCPU_MEM_WPROT_EN
  assign wperr = wpe[3];
`else
  assign wpe   = 4'b0000;
  assign wperr = 1'b0;
`endif

  dcpu_mem_responder #(
    .AW(10), .BASE(16'h0000), .WAIT(0), .WP_LIMIT(16'h0000)
  ) u0 (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat),
    .o_dat(dat[0]), .i_we(we), .i_cs(cs), .o_ack(ack[0])
`ifdef DCPU_MEM_WPROT_EN
    , .o_wp_err(wpe[0])
`endif
  );

  dcpu_mem_responder #(
    .AW(10), .BASE(16'h0400), .WAIT(2), .WP_LIMIT(16'h0000)
  ) u1 (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat),
    .o_dat(dat[1]), .i_we(we), .i_cs(cs), .o_ack(ack[1])
`ifdef DCPU_MEM_WPROT_EN
    , .o_wp_err(wpe[1])
`endif
  );

  dcpu_mem_responder #(
    .AW(10), .BASE(16'h0800), .WAIT(3), .WP_LIMIT(16'h0000)
  ) u2 (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat),
    .o_dat(dat[2]), .i_we(we), .i_cs(cs), .o_ack(ack[2])
`ifdef DCPU_MEM_WPROT_EN
    , .o_wp_err(wpe[2])
`endif
  );

  dcpu_mem_responder #(
    .AW(10), .BASE(16'h0000), .WAIT(0), .WP_LIMIT(16'h0100)
  ) uw (
    .i_clk(clk), .i_reset(rst), .i_addr(addr), .i_dat(wdat),
    .o_dat(dat[3]), .i_we(we), .i_cs(cs_w), .o_ack(ack[3])
`ifdef DCPU_MEM_WPROT_EN
    , .o_wp_err(wpe[3])
`endif
  );

  // reference model: word contents, last read word, sticky flag
  logic [15:0] mdl    [4][1024];
  bit          mvalid [4][1024];
  logic [15:0] mlast  [4];
  bit          mwp;

  typedef struct {
    logic [15:0] a;
    logic        w;
    logic [15:0] d;
    bit          keep;
    logic [15:0] exp;
  } vec_t;

  vec_t vec [10];

  function automatic int win(input logic [15:0] a);
    if (a < 16'h0C00) return int'(a >> 10);
    return -1;
  endfunction

  function automatic int lat_of(input int t);
    case (t)
      1: return 1 + 2;
      2: return 1 + 3;
      default: return 1 + 0;
    endcase
  endfunction

  function automatic bit prot(input int t, input logic [15:0] a);
`ifdef DCPU_MEM_WPROT_EN
    return (t == 3) && (a < 16'h0100);
`else
    return (t == 3) && 1'b0 && (a == 16'h0);
`endif
  endfunction

  task automatic chk(input string nm, input logic [15:0] got,
                     input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic xfer(input int bus, input logic [15:0] a, input logic w,
                      input logic [15:0] d, input bit keep,
                      output logic [15:0] rd, output logic wp);
    int tgt;
    int lat;
    tgt = (bus == 1) ? 3 : win(a);
    lat = -1;
    rd  = 'x;
    wp  = 1'b0;
    if (bus == 1 && cs) begin
      cs = 1'b0;
      @(posedge clk); #1;
    end
    addr = a; we = w; wdat = d;
    if (bus == 1) cs_w = 1'b1;
    else cs = 1'b1;
    for (int c = 0; c < 8 && lat < 0; c++) begin
      @(negedge clk);
      chk("stray_ack", 16'(ack & ~(4'b0001 << tgt)), 16'h0000);
      if (ack[tgt]) begin
        lat = c;
        rd  = dat[tgt];
        wp  = wperr;
      end
      @(posedge clk); #1;
    end
    chk("latency", 16'(lat), 16'(lat_of(tgt)));
    if (!keep) begin
      cs = 1'b0; cs_w = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic mxfer(input int bus, input logic [15:0] a, input logic w,
                       input logic [15:0] d, input bit keep,
                       output logic [15:0] rd);
    int          t;
    logic [15:0] exp;
    logic        wp;
    logic [9:0]  ix;
    t   = (bus == 1) ? 3 : win(a);
    ix  = a[9:0];
    exp = w ? mlast[t] : mdl[t][ix];
    xfer(bus, a, w, d, keep, rd, wp);
    if (w || mvalid[t][ix]) begin
      chk(w ? "wr_odat_hold" : "rd_data", rd, exp);
    end else begin
      mdl[t][ix]    = rd;
      mvalid[t][ix] = 1'b1;
    end
    if (!w) mlast[t] = mdl[t][ix];
    if (w && !prot(t, a)) begin
      mdl[t][ix]    = d;
      mvalid[t][ix] = 1'b1;
    end
    if (w && prot(t, a)) mwp = 1'b1;
`ifdef DCPU_MEM_WPROT_EN
    if (bus == 1 && w) chk("wp_err_at_ack", {15'b0, wp}, {15'b0, mwp});
`endif
  endtask

  task automatic abort_wr(input logic [15:0] a, input logic [15:0] d,
                          input int k);
    addr = a; we = 1'b1; wdat = d; cs = 1'b1;
    for (int j = 0; j < k; j++) begin
      @(negedge clk);
      chk("abort_noack", 16'(ack), 16'h0000);
      @(posedge clk); #1;
    end
    cs = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      chk("abort_noack", 16'(ack), 16'h0000);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] v;

    vec[0] = '{16'h0005, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    vec[1] = '{16'h0005, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
    vec[2] = '{16'h0805, 1'b1, 16'hBEEF, 1'b0, 16'h0000};
    vec[3] = '{16'h0805, 1'b0, 16'h0000, 1'b0, 16'hBEEF};
    vec[4] = '{16'h0410, 1'b1, 16'h4110, 1'b0, 16'h0000};
    vec[5] = '{16'h0410, 1'b0, 16'h0000, 1'b0, 16'h4110};
    vec[6] = '{16'h0001, 1'b1, 16'hAAAA, 1'b1, 16'hBEEF};
    vec[7] = '{16'h0001, 1'b0, 16'h0000, 1'b1, 16'hAAAA};
    vec[8] = '{16'h0001, 1'b1, 16'h5A5A, 1'b1, 16'hAAAA};
    vec[9] = '{16'h0001, 1'b0, 16'h0000, 1'b0, 16'h5A5A};

    errs = 0; checks = 0;
    rst = 1'b1; cs = 1'b0; cs_w = 1'b0; we = 1'b0;
    addr = 16'h0000; wdat = 16'h0000;
    for (int i = 0; i < 4; i++) mlast[i] = 16'h0000;
    mwp = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    chk("reset_ack", 16'(ack), 16'h0000);
    for (int i = 0; i < 4; i++) chk("reset_odat", dat[i], 16'h0000);
`ifdef DCPU_MEM_WPROT_EN
    chk("reset_wperr", {15'b0, wperr}, 16'h0000);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      mxfer(0, vec[i].a, vec[i].w, vec[i].d, vec[i].keep, rd);
      chk("vec_odat", rd, vec[i].exp);
    end

    abort_wr(16'h0805, 16'h1234, 2);
    mxfer(0, 16'h0805, 1'b0, 16'h0000, 1'b0, rd);
    chk("abort_kept", rd, 16'hBEEF);

    addr = 16'h0001; we = 1'b0; cs = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("hold_ack", 16'(ack[0]), 16'(c % 2));
      if (ack[0]) chk("hold_rd", dat[0], 16'h5A5A);
      @(posedge clk); #1;
    end
    cs = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    addr = 16'hF010; we = 1'b0; cs = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("oow_noack", 16'(ack), 16'h0000);
      @(posedge clk); #1;
    end
    addr = 16'h0010; we = 1'b1; wdat = 16'h0C0C;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("base_noack", 16'(ack[2:1]), 16'h0000);
      @(posedge clk); #1;
    end
    cs = 1'b0;
    mdl[0][16] = 16'h0C0C;
    mvalid[0][16] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    mxfer(0, 16'h0010, 1'b0, 16'h0000, 1'b0, rd);
    mxfer(0, 16'h0410, 1'b0, 16'h0000, 1'b0, rd);
    chk("base_hit", rd, 16'h4110);

    mxfer(1, 16'h0050, 1'b0, 16'h0000, 1'b0, rd);
    v = rd;
    mxfer(1, 16'h0050, 1'b1, 16'h5555, 1'b0, rd);
    mxfer(1, 16'h0050, 1'b0, 16'h0000, 1'b0, rd);
`ifdef DCPU_MEM_WPROT_EN
    chk("wp_blocked", rd, v);
`else
    chk("wp_off_commit", rd, 16'h5555);
`endif
    mxfer(1, 16'h0150, 1'b1, 16'h6666, 1'b0, rd);
    mxfer(1, 16'h0150, 1'b0, 16'h0000, 1'b0, rd);
    chk("wp_hi_commit", rd, 16'h6666);
`ifdef DCPU_MEM_WPROT_EN
    chk("wp_sticky", {15'b0, wperr}, 16'h0001);
`endif

    addr = 16'h0805; we = 1'b1; wdat = 16'h7777; cs = 1'b1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; cs = 1'b0; we = 1'b0;
    for (int i = 0; i < 4; i++) mlast[i] = 16'h0000;
    mwp = 1'b0;
    @(negedge clk);
    chk("rstmid_ack", 16'(ack), 16'h0000);
    for (int i = 0; i < 4; i++) chk("rstmid_odat", dat[i], 16'h0000);
`ifdef DCPU_MEM_WPROT_EN
    chk("rstmid_wperr", {15'b0, wperr}, 16'h0000);
`endif
    @(posedge clk); #1;
    mxfer(0, 16'h0805, 1'b0, 16'h0000, 1'b0, rd);
    chk("rstmid_kept", rd, 16'hBEEF);

    for (int n = 0; n < 300; n++) begin
      int          r;
      logic [15:0] a;
      logic        w;
      r = $urandom_range(0, 4);
      if (r == 4) begin
        addr = 16'h0C00 + 16'($urandom_range(0, 16'hF3FF));
        we = 1'($urandom); wdat = 16'($urandom); cs = 1'b1;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("rnd_oow", 16'(ack), 16'h0000);
          @(posedge clk); #1;
        end
        cs = 1'b0;
        @(posedge clk); #1;
      end else if (r == 3) begin
        a = ($urandom_range(0, 1) == 0) ? 16'h0040 : 16'h0140;
        a = a + 16'($urandom_range(0, 15));
        w = 1'($urandom);
        if (!w && !mvalid[3][a[9:0]]) w = 1'b1;
        mxfer(1, a, w, 16'($urandom), 1'b0, rd);
      end else begin
        a = 16'(r << 10) + 16'($urandom_range(0, 15));
        if (r > 0 && $urandom_range(0, 4) == 0) begin
          abort_wr(a, 16'($urandom), $urandom_range(1, r + 1));
        end else begin
          w = 1'($urandom);
          if (!w && !mvalid[r][a[9:0]]) w = 1'b1;
          mxfer(0, a, w, 16'($urandom), 1'($urandom), rd);
        end
      end
    end
    cs = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
